// File: rtl/magic_keys.sv
// magic_keys: synchronised, debounced magic/pause request levels with frame stretch and long-press reset.
// Define MAGIC_KBD_EN to merge the kbd_magic/kbd_pause hotkey pulses into the requests.

module magic_keys_chan #(
   parameter int DEBOUNCE_CYCLES = 280000
) (
   input  logic rst_n,
   input  logic clk28,
   input  logic btn_n_i,
   input  logic kbd_i,
   input  logic fe_i,
   output logic pressed_o,
   output logic req_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   logic          sync1_q;
   logic          sync2_q;
   logic          db_q;
   logic [CW-1:0] cnt_q;
   state_t        state_q;
   logic          req_q;

   // Two-stage synchroniser feeding a debounce counter; db_q is active-low like the button
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         db_q    <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_n_i;
         sync2_q <= sync1_q;
         if (sync2_q == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_q  <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1'b1);
         end
      end
   end

   // Request FSM: stretch each request until at least one frame edge has passed
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!db_q || kbd_i) begin
                  state_q <= ST_ACTIVE;
                  req_q   <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  req_q   <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               req_q <= 1'b1;
               if (fe_i) begin
                  state_q <= ST_HOLD;
               end else begin
                  state_q <= ST_ACTIVE;
               end
            end
            ST_HOLD: begin
               if (!db_q) begin
                  state_q <= ST_HOLD;
                  req_q   <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  req_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign pressed_o = ~db_q;
   assign req_o     = req_q;
endmodule

module magic_keys #(
   parameter int DEBOUNCE_CYCLES  = 280000,
   parameter int LONGPRESS_FRAMES = 100
) (
   input  logic rst_n,
   input  logic clk28,
   input  logic btn_magic_n,
   input  logic btn_pause_n,
   input  logic kbd_magic,
   input  logic kbd_pause,
   input  logic n_int,
   output logic magic_button,
   output logic pause_button,
   output logic reset_req
);
   localparam int LW = $clog2(LONGPRESS_FRAMES + 1);

   logic          n_int_q;
   logic          fe_s;
   logic          kbd_magic_s;
   logic          kbd_pause_s;
   logic          magic_pressed_s;
   logic          pause_pressed_s;
   logic [LW-1:0] lp_cnt_q;
   logic          reset_req_q;

`ifdef MAGIC_KBD_EN
   assign kbd_magic_s = kbd_magic;
   assign kbd_pause_s = kbd_pause;
`else
   logic kbd_unused_s;
   assign kbd_unused_s = kbd_magic ^ kbd_pause;
   assign kbd_magic_s  = 1'b0;
   assign kbd_pause_s  = 1'b0;
`endif

   // Delayed copy of n_int for falling-edge detection
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         n_int_q <= 1'b1;
      end else begin
         n_int_q <= n_int;
      end
   end

   assign fe_s = n_int_q & ~n_int;

   magic_keys_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_magic (
      .rst_n    (rst_n),
      .clk28    (clk28),
      .btn_n_i  (btn_magic_n),
      .kbd_i    (kbd_magic_s),
      .fe_i     (fe_s),
      .pressed_o(magic_pressed_s),
      .req_o    (magic_button)
   );

   magic_keys_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
      .rst_n    (rst_n),
      .clk28    (clk28),
      .btn_n_i  (btn_pause_n),
      .kbd_i    (kbd_pause_s),
      .fe_i     (fe_s),
      .pressed_o(pause_pressed_s),
      .req_o    (pause_button)
   );

   // Long-press frame counter; saturation blocks a second pulse until release
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         lp_cnt_q    <= '0;
         reset_req_q <= 1'b0;
      end else if (!magic_pressed_s) begin
         lp_cnt_q    <= '0;
         reset_req_q <= 1'b0;
      end else if (fe_s && (lp_cnt_q != LW'(LONGPRESS_FRAMES))) begin
         lp_cnt_q    <= lp_cnt_q + LW'(1'b1);
         reset_req_q <= (lp_cnt_q == LW'(LONGPRESS_FRAMES - 1));
      end else begin
         reset_req_q <= 1'b0;
      end
   end

   assign reset_req = reset_req_q;

   // Pause debounced level only feeds its request FSM
   logic pause_unused_s;
   assign pause_unused_s = pause_pressed_s;
endmodule

// File: tb/tb_magic_keys.sv
// Directed self-checking bench for magic_keys: DEBOUNCE_CYCLES=4, LONGPRESS_FRAMES=3, n_int low one cycle in twenty.
module tb_magic_keys;
`ifdef MAGIC_KBD_EN
   localparam bit KBD_EN = 1'b1;
`else
   localparam bit KBD_EN = 1'b0;
`endif

   logic rst_n;
   logic clk28;
   logic btn_magic_n;
   logic btn_pause_n;
   logic kbd_magic;
   logic kbd_pause;
   logic n_int;
   logic magic_button;
   logic pause_button;
   logic reset_req;

   int total;
   int bad;
   int cyc;

   magic_keys #(.DEBOUNCE_CYCLES(4), .LONGPRESS_FRAMES(3)) dut (
      .rst_n       (rst_n),
      .clk28       (clk28),
      .btn_magic_n (btn_magic_n),
      .btn_pause_n (btn_pause_n),
      .kbd_magic   (kbd_magic),
      .kbd_pause   (kbd_pause),
      .n_int       (n_int),
      .magic_button(magic_button),
      .pause_button(pause_button),
      .reset_req   (reset_req)
   );

   initial clk28 = 1'b0;
   always #5 clk28 = ~clk28;

   // One clock; n_int is low at every edge whose number is a multiple of 20, so fe fires there
   task automatic tick();
      @(posedge clk28);
      #1;
      cyc = cyc + 1;
      n_int = (((cyc + 1) % 20) == 0) ? 1'b0 : 1'b1;
   endtask

   task automatic align();
      while ((cyc % 20) != 0) tick();
   endtask

   task automatic settle();
      btn_magic_n = 1'b1;
      btn_pause_n = 1'b1;
      kbd_magic   = 1'b0;
      kbd_pause   = 1'b0;
      repeat (45) tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      total++;
      if (magic_button !== 1'b0) begin bad++; $display("FAIL reset_magic got=%b want=0", magic_button); end
      total++;
      if (pause_button !== 1'b0) begin bad++; $display("FAIL reset_pause got=%b want=0", pause_button); end
      total++;
      if (reset_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", reset_req); end
      rst_n = 1'b1;
      repeat (5) tick();
      total++;
      if ({magic_button, pause_button, reset_req} !== 3'b000) begin
         bad++; $display("FAIL post_reset_idle got=%b want=000", {magic_button, pause_button, reset_req});
      end
   endtask

   task automatic test_press_debounce();
      logic exp_b;
      align();
      for (int k = 1; k <= 45; k++) begin
         btn_magic_n = (k <= 30) ? 1'b0 : 1'b1;
         tick();
         exp_b = (k >= 7) && (k <= 36);
         total++;
         if (magic_button !== exp_b) begin bad++; $display("FAIL press_debounce k=%0d got=%b want=%b", k, magic_button, exp_b); end
         total++;
         if (reset_req !== 1'b0) begin bad++; $display("FAIL press_no_reset k=%0d got=%b want=0", k, reset_req); end
      end
   endtask

   task automatic test_bounce();
      align();
      for (int k = 1; k <= 30; k++) begin
         btn_pause_n = (k <= 20) ? ((((k - 1) / 2) % 2) == 1) : 1'b1;
         tick();
         total++;
         if (pause_button !== 1'b0) begin bad++; $display("FAIL bounce k=%0d got=%b want=0", k, pause_button); end
      end
   endtask

   task automatic test_kbd_stretch();
      logic exp_b;
      align();
      for (int k = 1; k <= 25; k++) begin
         kbd_pause = (k == 5);
         tick();
         exp_b = KBD_EN && (k >= 5) && (k <= 20);
         total++;
         if (pause_button !== exp_b) begin bad++; $display("FAIL kbd_stretch k=%0d got=%b want=%b", k, pause_button, exp_b); end
      end
      kbd_pause = 1'b0;
   endtask

   task automatic test_kbd_at_fe();
      logic exp_b;
      align();
      for (int k = 1; k <= 45; k++) begin
         kbd_magic = (k == 20);
         tick();
         exp_b = KBD_EN && (k >= 20) && (k <= 40);
         total++;
         if (magic_button !== exp_b) begin bad++; $display("FAIL kbd_at_fe k=%0d got=%b want=%b", k, magic_button, exp_b); end
         total++;
         if (reset_req !== 1'b0) begin bad++; $display("FAIL kbd_no_reset k=%0d got=%b want=0", k, reset_req); end
      end
      kbd_magic = 1'b0;
   endtask

   task automatic test_short_press();
      logic exp_b;
      align();
      for (int k = 1; k <= 25; k++) begin
         btn_magic_n = ((k >= 3) && (k <= 6)) ? 1'b0 : 1'b1;
         tick();
         exp_b = (k >= 9) && (k <= 20);
         total++;
         if (magic_button !== exp_b) begin bad++; $display("FAIL short_press k=%0d got=%b want=%b", k, magic_button, exp_b); end
      end
   endtask

   task automatic test_long_press();
      logic exp_m;
      logic exp_r;
      align();
      for (int k = 1; k <= 180; k++) begin
         btn_magic_n = (k <= 165) ? 1'b0 : 1'b1;
         tick();
         exp_m = (k >= 7) && (k <= 171);
         exp_r = (k == 60);
         total++;
         if (magic_button !== exp_m) begin bad++; $display("FAIL long_press_level k=%0d got=%b want=%b", k, magic_button, exp_m); end
         total++;
         if (reset_req !== exp_r) begin bad++; $display("FAIL long_press_req k=%0d got=%b want=%b", k, reset_req, exp_r); end
      end
   endtask

   task automatic test_both();
      logic exp_b;
      align();
      for (int k = 1; k <= 40; k++) begin
         btn_magic_n = (k <= 30) ? 1'b0 : 1'b1;
         btn_pause_n = (k <= 30) ? 1'b0 : 1'b1;
         tick();
         exp_b = (k >= 7) && (k <= 36);
         total++;
         if ({magic_button, pause_button} !== {exp_b, exp_b}) begin
            bad++; $display("FAIL both_channels k=%0d got=%b%b want=%b%b", k, magic_button, pause_button, exp_b, exp_b);
         end
      end
   endtask

   task automatic test_reset_mid_request();
      logic exp_b;
      align();
      btn_magic_n = 1'b0;
      repeat (10) tick();
      total++;
      if (magic_button !== 1'b1) begin bad++; $display("FAIL mid_req_before got=%b want=1", magic_button); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({magic_button, pause_button, reset_req} !== 3'b000) begin
         bad++; $display("FAIL mid_req_async got=%b want=000", {magic_button, pause_button, reset_req});
      end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         tick();
         exp_b = (j >= 7);
         total++;
         if (magic_button !== exp_b) begin bad++; $display("FAIL mid_req_recover j=%0d got=%b want=%b", j, magic_button, exp_b); end
      end
      btn_magic_n = 1'b1;
      repeat (50) tick();
      total++;
      if (magic_button !== 1'b0) begin bad++; $display("FAIL mid_req_release got=%b want=0", magic_button); end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      cyc         = 0;
      rst_n       = 1'b0;
      btn_magic_n = 1'b1;
      btn_pause_n = 1'b1;
      kbd_magic   = 1'b0;
      kbd_pause   = 1'b0;
      n_int       = 1'b1;
      test_reset();
      settle();
      test_press_debounce();
      settle();
      test_bounce();
      settle();
      test_kbd_stretch();
      settle();
      test_kbd_at_fe();
      settle();
      test_short_press();
      settle();
      test_long_press();
      settle();
      test_both();
      settle();
      test_reset_mid_request();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/magic_keys.md
# magic_keys

Front-end that produces the `magic_button` and `pause_button` request levels consumed by the magic/NMI engine. It synchronises and debounces the two physical buttons and merges in optional keyboard hotkey pulses. Each request is stretched so that it always spans at least one falling edge of `n_int`, which is where the engine samples it. A long hold of the magic button raises a one-cycle hard-reset request.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 280000: stable-input cycles before a debounced level changes (10 ms at 28 MHz).
- `LONGPRESS_FRAMES`, 100: `n_int` falling edges the magic button must stay held before `reset_req` fires (2 s at 50 Hz).

Ports:
- `rst_n`, input, 1: asynchronous, active-low reset.
- `clk28`, input, 1: 28 MHz system clock.
- `btn_magic_n`, input, 1: raw magic button, active-low, asynchronous.
- `btn_pause_n`, input, 1: raw pause button, active-low, asynchronous.
- `kbd_magic`, input, 1: one-cycle hotkey pulse from the keyboard decoder, synchronous to `clk28`.
- `kbd_pause`, input, 1: one-cycle hotkey pulse, synchronous to `clk28`.
- `n_int`, input, 1: frame interrupt, active-low, synchronous to `clk28`.
- `magic_button`, output, 1: magic request level.
- `pause_button`, output, 1: pause request level.
- `reset_req`, output, 1: one-cycle hard-reset request.

## Operation
- Raw buttons pass through a 2-FF synchroniser each, then a per-button debounce counter.
  - The counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
  - It clears whenever the synchronised level equals the debounced level.
  - The debounced level flips when the counter reaches `DEBOUNCE_CYCLES-1` with the input still different. The counter clears on the flip.
- Frame edge: `fe = n_int_d & ~n_int`, where `n_int_d` is `n_int` registered once.
- Two identical request FSMs, one per channel (magic, pause). A channel's source is its debounced button OR its `kbd_*` pulse.
  - IDLE: the output is 0. A debounced press or a kbd pulse moves the FSM to ACTIVE.
  - ACTIVE: the output is 1; the FSM waits for `fe`. On `fe` it goes to HOLD.
  - HOLD: the output is 1 while the debounced button is pressed. When the button is released it goes to IDLE. A kbd-only request finds the button already released, so it passes through HOLD for exactly one cycle.
- A kbd pulse or a new press arriving while the channel is in ACTIVE or HOLD is ignored; it does not extend or re-queue the request.
- The two channels are independent and may be active together.
- Long press, magic channel only:
  - A frame counter clears when the debounced magic button is released.
  - It increments on each `fe` while the button is pressed and saturates at `LONGPRESS_FRAMES`.
  - `reset_req` pulses for one cycle on the increment that reaches `LONGPRESS_FRAMES`. It cannot fire again until the button is released.
  - `magic_button` stays 1 throughout the hold.
- kbd inputs never drive the long-press counter.

## Timing
- Reset values: `magic_button`=0, `pause_button`=0, `reset_req`=0. Both FSMs are in IDLE, all counters are 0, both debounced levels are "released", both synchroniser stages are 1 and `n_int_d` is 1.
- Physical press to output high: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- kbd pulse at cycle T: output high at T+1.
- The output falls 1 cycle after the debounced release, or 1 cycle after `fe` when the button is already released.
- Minimum high time is one full `fe`, so the engine always observes the request on an `n_int` falling edge.
- `fe` and release in the same cycle: go ACTIVE→HOLD, then HOLD→IDLE on the next cycle.
- `fe` and a kbd pulse in the same cycle while in IDLE: go to ACTIVE. That `fe` does not count; the FSM waits for the next one.
- `rst_n` asserted mid-request: all outputs drop to 0 immediately and asynchronously. After reset the button must debounce again from "released".
- `reset_req` is registered and fires in the cycle after the qualifying `fe`.

## Configuration
- `MAGIC_KBD_EN`
  - Defined: `kbd_magic` and `kbd_pause` feed the FSMs as described above.
  - Undefined: both kbd inputs are ignored internally (the ports remain). Requests come only from the physical buttons.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONGPRESS_FRAMES`=3, `n_int` low for 1 cycle every 20 cycles.
- Press debounce: hold `btn_magic_n`=0 for 30 cycles → `magic_button` rises 7 cycles after the press, stays 1 until 7 cycles after release, and `reset_req` stays 0.
- Bounce rejection: toggle `btn_pause_n` every 2 cycles for 20 cycles → `pause_button` stays 0.
- Kbd stretch (`MAGIC_KBD_EN` defined): `kbd_pause` pulse at cycle 5 → `pause_button` is high from cycle 6 until the cycle after the first `fe`. The same test with the macro undefined → `pause_button` stays 0.
- Short press shorter than a frame: debounced press lasts 3 cycles with no `fe` in between → `magic_button` stays high until the cycle after the next `fe`.
- Long press: hold the magic button across 3 `fe` → exactly one `reset_req` pulse, 1 cycle after the 3rd `fe`. Keep holding 5 more frames → no further pulse.
- Reset mid-request: assert `rst_n`=0 while `magic_button`=1 → output 0 immediately. Release reset with the button still held → output returns after `DEBOUNCE_CYCLES`+3 cycles.
